// File: rtl/goose_pkg.sv
// Shared goose-run playfield definitions: run-state encodings, screen geometry
// and the LFSR seed used by the obstacle spacing generator.
package goose_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } run_state_t;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int FLOOR_TOP = 380;

   localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), advances one step when en is high.
module lfsr8
   import goose_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [7:0] q
);

   logic fb;

   assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SEED;
      end else if (en) begin
         q <= {q[6:0], fb};
      end
   end

endmodule

// File: rtl/floor_scroll_ctrl.sv
// Per-frame ground-layer controller: run FSM, floor scroll, speed ramp, score
// and a single ground obstacle, plus combinational floor/stripe/obstacle masks.
module floor_scroll_ctrl
   import goose_pkg::*;
#(
   parameter int STRIPE_ROWS = 4,
   parameter int SPEED_INIT  = 2,
   parameter int SPEED_MAX   = 8,
   parameter int RAMP_FRAMES = 600,
   parameter int OBS_W       = 16,
   parameter int OBS_H       = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        start,
   input  logic        collision,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic        floor_px,
   output logic        stripe_px,
   output logic        obstacle_px,
   output logic [1:0]  run_state,
   output logic [3:0]  speed,
   output logic [15:0] score
);

   localparam int RAMP_W = $clog2(RAMP_FRAMES);

   localparam logic [9:0]  SCR_W10      = 10'(SCREEN_W);
   localparam logic [10:0] SCR_W11      = 11'(SCREEN_W);
   localparam logic [9:0]  Y_FLOOR      = 10'(FLOOR_TOP);
   localparam logic [9:0]  Y_LAST       = 10'(SCREEN_H - 1);
   localparam logic [9:0]  Y_STRIPE_END = 10'(FLOOR_TOP + STRIPE_ROWS);
   localparam logic [9:0]  Y_OBS_TOP    = 10'(FLOOR_TOP - OBS_H);
   localparam logic [3:0]  SPD_INIT     = 4'(SPEED_INIT);
   localparam logic [3:0]  SPD_MAX      = 4'(SPEED_MAX);
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
   localparam logic [6:0]  GAP_START    = 7'd32;
   localparam logic [6:0]  GAP_BASE     = 7'd30;

   run_state_t state, state_nxt;
   logic       restart;
   logic       run_upd;

   logic [9:0]        scroll_x;
   logic [3:0]        speed_r;
   logic [RAMP_W-1:0] ramp_cnt;
   logic [15:0]       score_r;
   logic              obs_active;
   logic [9:0]        obs_x;
   logic [6:0]        gap_cnt;
   logic [7:0]        lfsr_q;
   logic              lfsr_unused;

   logic [10:0] scroll_sum;
   logic [9:0]  scroll_nxt;
   logic [9:0]  speed_ext;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (frame_tick && start)     state_nxt = ST_RUN;
         ST_RUN:  if (frame_tick && collision) state_nxt = ST_OVER;
         ST_OVER: if (frame_tick && start)     state_nxt = ST_RUN;
         default:                              state_nxt = ST_IDLE;
      endcase
   end

   // FSM: per-frame actions; a colliding frame performs no RUN update
   always_comb begin
      restart = 1'b0;
      run_upd = 1'b0;
      case (state)
         ST_IDLE, ST_OVER: restart = frame_tick & start;
         ST_RUN:           run_upd = frame_tick & ~collision;
         default: ;
      endcase
   end

   lfsr8 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (run_upd),
      .q     (lfsr_q)
   );

   assign lfsr_unused = &{1'b0, lfsr_q[7:6]};

   assign speed_ext  = {6'd0, speed_r};
   assign scroll_sum = {1'b0, scroll_x} + {7'd0, speed_r};
   assign scroll_nxt = (scroll_sum >= SCR_W11) ? 10'(scroll_sum - SCR_W11)
                                               : scroll_sum[9:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scroll_x   <= 10'd0;
         speed_r    <= SPD_INIT;
         ramp_cnt   <= '0;
         score_r    <= 16'd0;
         obs_active <= 1'b0;
         obs_x      <= SCR_W10;
         gap_cnt    <= 7'd0;
      end else if (restart) begin
         scroll_x   <= 10'd0;
         speed_r    <= SPD_INIT;
         ramp_cnt   <= '0;
         score_r    <= 16'd0;
         obs_active <= 1'b0;
         obs_x      <= SCR_W10;
         gap_cnt    <= GAP_START;
      end else if (run_upd) begin
         scroll_x <= scroll_nxt;
         if (score_r != 16'hFFFF) begin
            score_r <= score_r + 16'd1;
         end
         if (ramp_cnt == RAMP_LAST) begin
            ramp_cnt <= '0;
            if (speed_r < SPD_MAX) begin
               speed_r <= speed_r + 4'd1;
            end
         end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
         end
         // obstacle leaves on the left once it cannot move a full step
         if (obs_active) begin
            if (obs_x < speed_ext) begin
               obs_active <= 1'b0;
               gap_cnt    <= GAP_BASE + {1'b0, lfsr_q[5:0]};
            end else begin
               obs_x <= obs_x - speed_ext;
            end
         end else if (gap_cnt != 7'd0) begin
            gap_cnt <= gap_cnt - 7'd1;
         end else begin
            obs_active <= 1'b1;
            obs_x      <= SCR_W10;
         end
      end
   end

   logic [10:0] tex_sum;
   logic [10:0] tex_x;
   logic [10:0] obs_end;

   // texture column is taken modulo the screen width so the pattern wraps
   assign tex_sum = {1'b0, x} + {1'b0, scroll_x};
   assign tex_x   = (tex_sum >= SCR_W11) ? (tex_sum - SCR_W11) : tex_sum;
   assign obs_end = {1'b0, obs_x} + 11'(OBS_W);

   always_comb begin
      floor_px    = (x < SCR_W10) && (y >= Y_FLOOR) && (y <= Y_LAST);
      stripe_px   = floor_px && (y < Y_STRIPE_END) && !tex_x[4];
      obstacle_px = obs_active && (x >= obs_x) && ({1'b0, x} < obs_end) &&
                    (y >= Y_OBS_TOP) && (y < Y_FLOOR);
   end

   assign run_state = state;
   assign speed     = speed_r;
   assign score     = score_r;

endmodule

// File: tb/tb_floor_scroll_ctrl.sv
// Directed bench for floor_scroll_ctrl: pixel-mask vector tables plus frame
// sequences for speed ramp, obstacle life cycle, collision freeze and reset.
module tb_floor_scroll_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        start = 1'b0;
   logic        collision = 1'b0;
   logic [9:0]  x = 10'd0;
   logic [9:0]  y = 10'd0;
   logic        floor_px, stripe_px, obstacle_px;
   logic [1:0]  run_state;
   logic [3:0]  speed;
   logic [15:0] score;

   int n_vec = 0;
   int n_bad = 0;

   int m_scroll, m_speed, m_ramp, m_score;

   typedef struct {
      int   px;
      int   py;
      logic fl;
      logic st;
      logic ob;
   } pxvec_t;

   pxvec_t rst_tab[10];
   pxvec_t obs_tab[6];

   floor_scroll_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .start       (start),
      .collision   (collision),
      .x           (x),
      .y           (y),
      .floor_px    (floor_px),
      .stripe_px   (stripe_px),
      .obstacle_px (obstacle_px),
      .run_state   (run_state),
      .speed       (speed),
      .score       (score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_vec(input string nm, input pxvec_t v);
      x = 10'(v.px);
      y = 10'(v.py);
      #1;
      chk($sformatf("%s_floor(%0d,%0d)", nm, v.px, v.py), int'(floor_px), int'(v.fl));
      chk($sformatf("%s_stripe(%0d,%0d)", nm, v.px, v.py), int'(stripe_px), int'(v.st));
      chk($sformatf("%s_obs(%0d,%0d)", nm, v.px, v.py), int'(obstacle_px), int'(v.ob));
   endtask

   task automatic chk_stripe(input string nm, input int px, input int py, input int exp);
      x = 10'(px);
      y = 10'(py);
      #1;
      chk($sformatf("%s_stripe(%0d,%0d)", nm, px, py), int'(stripe_px), exp);
   endtask

   task automatic chk_obs(input string nm, input int px, input int py, input int exp);
      x = 10'(px);
      y = 10'(py);
      #1;
      chk($sformatf("%s_obs(%0d,%0d)", nm, px, py), int'(obstacle_px), exp);
   endtask

   // the two columns where the texture coordinate is 15 and 16 pin the scroll value
   task automatic chk_scroll(input string nm);
      chk_stripe({nm, "_lo"}, (655 - m_scroll) % 640, 380, 1);
      chk_stripe({nm, "_hi"}, (656 - m_scroll) % 640, 380, 0);
   endtask

   task automatic tick(input logic s, input logic c);
      @(negedge clk);
      start      = s;
      collision  = c;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      start      = 1'b0;
      collision  = 1'b0;
   endtask

   task automatic model_restart();
      m_scroll = 0;
      m_speed  = 2;
      m_ramp   = 0;
      m_score  = 0;
   endtask

   task automatic run_frame(input logic s);
      int  sum;
      bit  wrapped;
      sum     = m_scroll + m_speed;
      wrapped = (sum >= 640);
      m_scroll = wrapped ? sum - 640 : sum;
      if (m_ramp == 599) begin
         m_ramp = 0;
         if (m_speed < 8) m_speed++;
      end else begin
         m_ramp++;
      end
      m_score++;
      tick(s, 1'b0);
      if (wrapped) chk_scroll($sformatf("wrap_k%0d", m_score));
   endtask

   task automatic run_to(input int k);
      while (m_score < k) run_frame(1'b0);
   endtask

   initial begin
      rst_tab[0] = '{0,   380, 1'b1, 1'b1, 1'b0};
      rst_tab[1] = '{16,  380, 1'b1, 1'b0, 1'b0};
      rst_tab[2] = '{15,  383, 1'b1, 1'b1, 1'b0};
      rst_tab[3] = '{0,   384, 1'b1, 1'b0, 1'b0};
      rst_tab[4] = '{639, 479, 1'b1, 1'b0, 1'b0};
      rst_tab[5] = '{640, 400, 1'b0, 1'b0, 1'b0};
      rst_tab[6] = '{0,   379, 1'b0, 1'b0, 1'b0};
      rst_tab[7] = '{100, 480, 1'b0, 1'b0, 1'b0};
      rst_tab[8] = '{32,  381, 1'b1, 1'b1, 1'b0};
      rst_tab[9] = '{48,  382, 1'b1, 1'b0, 1'b0};

      obs_tab[0] = '{624, 356, 1'b0, 1'b0, 1'b1};
      obs_tab[1] = '{639, 379, 1'b0, 1'b0, 1'b1};
      obs_tab[2] = '{640, 379, 1'b0, 1'b0, 1'b0};
      obs_tab[3] = '{624, 355, 1'b0, 1'b0, 1'b0};
      obs_tab[4] = '{623, 370, 1'b0, 1'b0, 1'b0};
      obs_tab[5] = '{630, 370, 1'b0, 1'b0, 1'b1};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_state", int'(run_state), 0);
      chk("rst_speed", int'(speed), 2);
      chk("rst_score", int'(score), 0);
      for (int i = 0; i < 10; i++) chk_vec("rst", rst_tab[i]);
      @(negedge clk);
      rst_n = 1'b1;

      // start without a frame tick does nothing
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("idle_no_tick", int'(run_state), 0);

      tick(1'b1, 1'b0);
      model_restart();
      chk("start_state", int'(run_state), 1);
      chk("start_speed", int'(speed), 2);
      chk("start_score", int'(score), 0);
      chk_scroll("start_scroll");

      run_frame(1'b0);
      chk("k1_score", int'(score), 1);
      chk_stripe("k1_x13", 13, 380, 1);
      chk_stripe("k1_x14", 14, 380, 0);

      // start during RUN must not restart the run
      run_frame(1'b1);
      chk("run_start_state", int'(run_state), 1);
      chk("run_start_score", int'(score), 2);

      run_to(33);
      chk_obs("spawn_offscreen", 639, 370, 0);
      run_to(41);
      chk_scroll("k41_scroll");
      for (int i = 0; i < 6; i++) chk_vec("obs624", obs_tab[i]);

      // collision level without a frame tick is ignored
      @(negedge clk);
      collision = 1'b1;
      repeat (3) @(negedge clk);
      collision = 1'b0;
      #1;
      chk("coll_no_tick_state", int'(run_state), 1);
      chk("coll_no_tick_score", int'(score), 41);

      run_to(352);
      chk_obs("obs2_x1", 1, 370, 0);
      chk_obs("obs2_x2", 2, 370, 1);
      run_to(353);
      chk_obs("obs0_x0", 0, 370, 1);
      chk_obs("obs0_x15", 15, 370, 1);
      chk_obs("obs0_x16", 16, 370, 0);
      run_to(354);
      chk_obs("obs_gone", 0, 370, 0);

      run_to(599);
      chk("k599_speed", int'(speed), 2);
      run_to(600);
      chk("k600_speed", int'(speed), 3);
      run_to(3599);
      chk("k3599_speed", int'(speed), 7);
      run_to(3600);
      chk("k3600_speed", int'(speed), 8);
      run_to(4200);
      chk("k4200_speed", int'(speed), 8);
      chk("k4200_score", int'(score), 4200);
      chk_scroll("k4200_scroll");

      // collision freezes the frame it arrives on
      tick(1'b0, 1'b1);
      chk("over_state", int'(run_state), 2);
      chk("over_score", int'(score), 4200);
      chk_scroll("over_scroll");
      repeat (9) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk("frozen_state", int'(run_state), 2);
      chk("frozen_score", int'(score), 4200);
      chk("frozen_speed", int'(speed), 8);
      chk_scroll("frozen_scroll");

      tick(1'b1, 1'b0);
      model_restart();
      chk("restart_state", int'(run_state), 1);
      chk("restart_score", int'(score), 0);
      chk("restart_speed", int'(speed), 2);
      chk_scroll("restart_scroll");
      chk_obs("restart_obs", 624, 356, 0);

      run_to(41);
      chk_obs("rerun_obs", 624, 356, 1);
      chk("rerun_score", int'(score), 41);

      // asynchronous reset between clock edges
      @(negedge clk);
      x = 10'd624;
      y = 10'd356;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(run_state), 0);
      chk("async_rst_obs", int'(obstacle_px), 0);
      chk("async_rst_score", int'(score), 0);
      chk("async_rst_speed", int'(speed), 2);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
